qspi_fetch_buffer: RTL and testbench

//  Fetch-side consumer of qspi_flash. Turns 32-bit word fetch requests into qspi_flash

---
 rtl/qspi_fetch_buffer.sv | 167 ++++++++++++++++
 tb/tb_qspi_fetch_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_fetch_buffer.sv
// qspi_fetch_buffer: turns 32-bit word fetches into qspi_flash read sessions.
// A single continuous read fills a small prefetch FIFO; sequential fetches pop
// from it, and any other fetch flushes the FIFO and restarts the read.
module qspi_fetch_buffer #(
    parameter int unsigned PREFETCH_WORDS = 2,
    parameter int unsigned RESTART_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [23:0] flash_addr,
    output logic        flash_do_read,
    input  logic        flash_setup_done,
    input  logic        flash_data_ready,
    input  logic [7:0]  flash_data
);

    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned WORD_ADDR_W = 22;
    localparam int unsigned CNT_W       = $clog2(PREFETCH_WORDS) + 1;
    localparam int unsigned PTR_W       = (PREFETCH_WORDS > 1) ? $clog2(PREFETCH_WORDS) : 1;
    localparam int unsigned GAP_W       = $clog2(RESTART_GAP + 1);

    typedef enum logic [1:0] {WAIT_SETUP, STOPPED, GAP, STREAMING} fill_state_t;

    fill_state_t              state, state_next;
    logic [ADDR_W-1:0]        stream_addr;
    logic [23:0]              partial;
    logic [31:0]              fifo_mem [PREFETCH_WORDS];
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         count, count_next;
    logic [GAP_W-1:0]         gap_cnt, gap_cnt_d;
    logic                     pending, pending_d;
    logic                     req_ready_d, resp_valid_d, do_read_d;
    logic [31:0]              resp_data_d;
    logic [ADDR_W-1:0]        flash_addr_d;

    logic                     accept, is_hit, is_inflight, is_miss;
    logic                     byte_in, lane3, want_bypass, push, pop;
    logic [WORD_ADDR_W-1:0]   req_word, stream_word, head_word;
    logic [31:0]              word_done;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    // Request classification and byte-stream bookkeeping
    assign accept      = req_valid && req_ready;
    assign req_word    = req_addr[23:2];
    assign stream_word = stream_addr[23:2];
    assign head_word   = stream_word - WORD_ADDR_W'(count);
    assign is_hit      = accept && (count != '0) && (head_word == req_word);
    assign is_inflight = accept && (count == '0) && (state == STREAMING) && (stream_word == req_word);
    assign is_miss     = accept && !is_hit && !is_inflight;
    assign byte_in     = flash_data_ready && (state == STREAMING) && !is_miss;
    assign lane3       = byte_in && (stream_addr[1:0] == 2'd3);
    assign word_done   = {flash_data, partial};
    assign want_bypass = lane3 && (pending || is_inflight);
    assign push        = lane3 && !want_bypass;
    assign pop         = is_hit;
    assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

    // Fill FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_SETUP;
        else     state <= state_next;
    end

    // Fill FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SETUP: if (flash_setup_done) state_next = STOPPED;
            STOPPED: begin
                if (is_miss)                                          state_next = GAP;
                else if (pop && (count == CNT_W'(PREFETCH_WORDS)))    state_next = GAP;
            end
            GAP: begin
                if (is_miss)                                          state_next = GAP;
                else if (gap_cnt == GAP_W'(RESTART_GAP - 1))          state_next = STREAMING;
            end
            STREAMING: begin
                if (is_miss)                                          state_next = GAP;
                else if (push && (count_next == CNT_W'(PREFETCH_WORDS))) state_next = STOPPED;
            end
            default: state_next = WAIT_SETUP;
        endcase
    end

    // Next values of the registered outputs and request bookkeeping
    always_comb begin
        do_read_d    = (state_next == STREAMING);
        flash_addr_d = flash_addr;
        gap_cnt_d    = '0;
        pending_d    = pending;
        resp_valid_d = is_hit || want_bypass;
        resp_data_d  = resp_data;
        if ((state == GAP) && (state_next == STREAMING)) flash_addr_d = stream_addr;
        if ((state == GAP) && (state_next == GAP) && !is_miss) gap_cnt_d = gap_cnt + GAP_W'(1);
        if (is_miss)          pending_d = 1'b1;
        else if (want_bypass) pending_d = 1'b0;
        else if (is_inflight) pending_d = 1'b1;
        if (is_hit)           resp_data_d = fifo_mem[rd_ptr];
        else if (want_bypass) resp_data_d = word_done;
        req_ready_d = (state_next != WAIT_SETUP) && !pending_d;
    end

    // Output and control registers; do_read drops asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            flash_do_read <= 1'b0;
            flash_addr    <= '0;
            gap_cnt       <= '0;
            pending       <= 1'b0;
        end else begin
            req_ready     <= req_ready_d;
            resp_valid    <= resp_valid_d;
            resp_data     <= resp_data_d;
            flash_do_read <= do_read_d;
            flash_addr    <= flash_addr_d;
            gap_cnt       <= gap_cnt_d;
            pending       <= pending_d;
        end
    end

    // Stream address, partial word assembly and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stream_addr <= '0;
            partial     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (is_miss) begin
            stream_addr <= {req_word, 2'b00};
            partial     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (byte_in) begin
                stream_addr <= stream_addr + ADDR_W'(1);
                case (stream_addr[1:0])
                    2'd0:    partial[7:0]   <= flash_data;
                    2'd1:    partial[15:8]  <= flash_data;
                    2'd2:    partial[23:16] <= flash_data;
                    default: ;
                endcase
            end
            if (push) wr_ptr <= (wr_ptr == PTR_W'(PREFETCH_WORDS - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(PREFETCH_WORDS - 1)) ? '0 : rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Prefetch word storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= word_done;
    end

endmodule

// File: tb/tb_qspi_fetch_buffer.sv
// Bench for qspi_fetch_buffer: flash byte-source model, directed vector table,
// randomized fetch traffic checked against flash contents, mid-word reset.
module tb_qspi_fetch_buffer;

    localparam int unsigned PW = 2;
    localparam int unsigned RG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic        req_ready, resp_valid, flash_do_read;
    logic [31:0] resp_data;
    logic [23:0] flash_addr;
    logic        flash_setup_done = 1'b0;
    logic        flash_data_ready = 1'b0;
    logic [7:0]  flash_data = '0;

    always #5 clk = ~clk;

    qspi_fetch_buffer #(.PREFETCH_WORDS(PW), .RESTART_GAP(RG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .flash_addr(flash_addr), .flash_do_read(flash_do_read),
        .flash_setup_done(flash_setup_done), .flash_data_ready(flash_data_ready),
        .flash_data(flash_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_fetch = 0;
    int n_resp = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Flash contents: byte value as a function of its address
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return 8'((a[7:0] + 8'd1) * 8'h11) ^ a[23:16] ^ 8'(a[15:9]);
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {fbyte(b + 24'd3), fbyte(b + 24'd2), fbyte(b + 24'd1), fbyte(b)};
    endfunction

    // Flash model: streams bytes from flash_addr while do_read is high
    logic [23:0] fl_addr, fl_start;
    logic        fl_active = 1'b0;
    int          fl_lat = 0;
    int          low_cnt = 1000;
    int          sess_bytes = 0;
    int          last_sess_bytes = 0;
    int          n_starts = 0;
    logic [23:0] start_log [256];

    always @(negedge clk) begin
        if (flash_do_read !== 1'b1) begin
            if (fl_active) begin
                fl_active = 1'b0;
                last_sess_bytes = sess_bytes;
            end
            low_cnt++;
            flash_data_ready = ($urandom % 6 == 0);
            flash_data = 8'($urandom);
        end else begin
            if (!fl_active) begin
                n_cmp++;
                if (low_cnt < int'(RG)) begin
                    n_err++;
                    $display("FAIL restart_gap: do_read low %0d cycles, required >= %0d", low_cnt, RG);
                end
                fl_active = 1'b1;
                fl_addr = flash_addr;
                fl_start = flash_addr;
                start_log[n_starts % 256] = flash_addr;
                n_starts++;
                sess_bytes = 0;
                fl_lat = 1 + int'($urandom % 3);
                flash_data_ready = 1'b0;
            end else begin
                check32("flash_addr_stable", 32'(flash_addr), 32'(fl_start));
                if (fl_lat > 0) begin
                    fl_lat--;
                    flash_data_ready = 1'b0;
                end else if ($urandom % 4 != 0) begin
                    flash_data_ready = 1'b1;
                    flash_data = fbyte(fl_addr);
                    fl_addr = fl_addr + 24'd1;
                    sess_bytes++;
                end else begin
                    flash_data_ready = 1'b0;
                end
            end
            low_cnt = 0;
        end
    end

    // Count every response pulse
    always @(negedge clk) begin
        if (resp_valid === 1'b1) n_resp++;
    end

    task automatic fetch(input logic [23:0] a, input logic [31:0] expd, input bit want_hit, output int lat);
        int w;
        w = 0;
        lat = -1;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: req_ready=%b after 200 cycles, required 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 24'($urandom);
        n_fetch++;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL resp_timeout: no resp_valid for addr 0x%06h, required one", a);
        end else begin
            check32("resp_data", resp_data, expd);
        end
        if (want_hit) check32("hit_latency", 32'(lat), 32'd1);
    endtask

    task automatic wait_idle();
        int low, t;
        low = 0;
        t = 0;
        while (low < 10 && t < 400) begin
            @(negedge clk);
            low = (flash_do_read === 1'b0) ? low + 1 : 0;
            t++;
        end
        if (low < 10) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: do_read never settled low, required stop");
        end
    endtask

    task automatic wait_stream();
        int t;
        t = 0;
        @(negedge clk);
        while (!(flash_do_read === 1'b1 && sess_bytes >= 1) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (flash_do_read !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL stream_timeout: do_read=%b, required 1", flash_do_read);
        end
    endtask

    task automatic wait_start(input int s0);
        int t;
        t = 0;
        while (n_starts <= s0 && t < 200) begin
            @(negedge clk);
            t++;
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] exp_data;
        bit          hit;
        int          pre;        // 0 none, 1 wait for stopped stream, 2 wait for active stream
        int          exp_bytes;  // session byte count to check before issuing (0 = skip)
        bit          chk_start;
        logic [23:0] exp_start;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat, s0;
        logic [23:0] ra;

        vecs[0] = '{addr:24'h000100, exp_data:32'h44332211, hit:1'b0, pre:0, exp_bytes:0,  chk_start:1'b1, exp_start:24'h000100};
        vecs[1] = '{addr:24'h000104, exp_data:32'h88776655, hit:1'b1, pre:1, exp_bytes:12, chk_start:1'b1, exp_start:24'h00010C};
        vecs[2] = '{addr:24'h000108, exp_data:word_at(24'h000108), hit:1'b1, pre:0, exp_bytes:0, chk_start:1'b0, exp_start:24'h0};
        vecs[3] = '{addr:24'h00010C, exp_data:word_at(24'h00010C), hit:1'b0, pre:0, exp_bytes:0, chk_start:1'b0, exp_start:24'h0};
        vecs[4] = '{addr:24'h8F4290, exp_data:word_at(24'h8F4290), hit:1'b0, pre:2, exp_bytes:0, chk_start:1'b1, exp_start:24'h8F4290};
        vecs[5] = '{addr:24'hFFFFFC, exp_data:word_at(24'hFFFFFC), hit:1'b0, pre:0, exp_bytes:0, chk_start:1'b1, exp_start:24'hFFFFFC};
        vecs[6] = '{addr:24'h000000, exp_data:word_at(24'h000000), hit:1'b1, pre:1, exp_bytes:12, chk_start:1'b1, exp_start:24'h000008};
        vecs[7] = '{addr:24'h000004, exp_data:word_at(24'h000004), hit:1'b1, pre:0, exp_bytes:0, chk_start:1'b0, exp_start:24'h0};

        // Reset values and setup wait
        #1 rst = 1'b1;
        #1;
        check32("rst_req_ready",  32'(req_ready), 32'd0);
        check32("rst_resp_valid", 32'(resp_valid), 32'd0);
        check32("rst_resp_data",  resp_data, 32'd0);
        check32("rst_do_read",    32'(flash_do_read), 32'd0);
        check32("rst_flash_addr", 32'(flash_addr), 32'd0);
        #21 rst = 1'b0;
        repeat (10) @(negedge clk);
        check32("setup_req_ready", 32'(req_ready), 32'd0);
        check32("setup_do_read",   32'(flash_do_read), 32'd0);
        flash_setup_done = 1'b1;
        @(posedge clk); #1;
        check32("setup_done_ready", 32'(req_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre == 1)      wait_idle();
            else if (vecs[i].pre == 2) wait_stream();
            if (vecs[i].exp_bytes != 0) check32("session_bytes", 32'(last_sess_bytes), 32'(vecs[i].exp_bytes));
            s0 = n_starts;
            fetch(vecs[i].addr, vecs[i].exp_data, vecs[i].hit, lat);
            if (vecs[i].chk_start) begin
                wait_start(s0);
                check32("start_addr", 32'(start_log[s0 % 256]), 32'(vecs[i].exp_start));
            end
        end

        // Randomized traffic: sequential runs, jumps, repeats and wrap region
        ra = 24'h000800;
        for (int k = 0; k < 60; k++) begin
            int r;
            r = int'($urandom % 10);
            if (r < 6)      ra = ra + 24'd4;
            else if (r < 8) ra = 24'($urandom_range(0, 32'hFFFF)) & 24'hFFFFFC;
            else if (r < 9) ra = 24'hFFFFF0 + 24'(4 * ($urandom % 4));
            repeat ($urandom % 12) @(negedge clk);
            fetch(ra | 24'($urandom % 4), word_at(ra), 1'b0, lat);
        end

        // Reset with two bytes of a word received
        wait_idle();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = 24'h400200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (!(fl_active && sess_bytes == 2) && t < 200) begin
                @(posedge clk); #2;
                t++;
            end
        end
        check32("mid_word_bytes", 32'(sess_bytes), 32'd2);
        rst = 1'b1;
        #1;
        check32("mid_rst_req_ready",  32'(req_ready), 32'd0);
        check32("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check32("mid_rst_resp_data",  resp_data, 32'd0);
        check32("mid_rst_do_read",    32'(flash_do_read), 32'd0);
        check32("mid_rst_flash_addr", 32'(flash_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = n_starts;
        fetch(24'h400204, word_at(24'h400204), 1'b0, lat);
        wait_start(s0);
        check32("post_rst_miss_start", 32'(start_log[s0 % 256]), 32'h400204);

        repeat (5) @(negedge clk);
        check32("resp_count", 32'(n_resp), 32'(n_fetch));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
